// File: rtl/ascon_io_loader.sv
// Assembles ASCON key/nonce/data blocks and commands from 32-bit words strobed in over GPIO pads.
// Define ASCON_LOADER_STB_SYNC_EN when pad_stb_i is asynchronous, to add a 2-flop synchronizer.
module ascon_io_loader (
  input  logic         wb_clk_i,
  input  logic         wb_rst_ni,
  input  logic [31:0]  pad_dat_i,
  input  logic [1:0]   pad_sel_i,
  input  logic         pad_stb_i,
  output logic         pad_busy_o,
  output logic [127:0] key_o,
  output logic [127:0] nonce_o,
  output logic         kn_vld_o,
  output logic [63:0]  blk_dat_o,
  output logic         blk_vld_o,
  output logic         blk_last_o,
  input  logic         blk_rdy_i,
  output logic         start_o,
  output logic         mode_o,
  output logic         err_o
);

  localparam logic [1:0] SEL_KEY   = 2'd0;
  localparam logic [1:0] SEL_NONCE = 2'd1;
  localparam logic [1:0] SEL_DATA  = 2'd2;
  localparam logic [1:0] SEL_CMD   = 2'd3;

  localparam int CMD_START = 0;
  localparam int CMD_MODE  = 1;
  localparam int CMD_LAST  = 2;
  localparam int CMD_CLEAR = 3;

  typedef enum logic [1:0] {S_IDLE, S_HALF, S_FULL} blk_state_t;

  logic       stb_now, stb_prev, ev;
  blk_state_t state;
  logic [1:0] key_cnt, nonce_cnt;
  logic       key_full, nonce_full, last_pend;

`ifdef ASCON_LOADER_STB_SYNC_EN
  // [0],[1] synchronize; [2] is the edge-detect history
  logic [2:0] stb_pipe;
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni)
    if (!wb_rst_ni) stb_pipe <= '0;
    else            stb_pipe <= {stb_pipe[1:0], pad_stb_i};
  assign stb_now  = stb_pipe[1];
  assign stb_prev = stb_pipe[2];
`else
  logic stb_q;
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni)
    if (!wb_rst_ni) stb_q <= 1'b0;
    else            stb_q <= pad_stb_i;
  assign stb_now  = pad_stb_i;
  assign stb_prev = stb_q;
`endif

  assign ev = stb_now & ~stb_prev;

  logic ev_key, ev_nonce, ev_dat, ev_cmd;
  assign ev_key   = ev && (pad_sel_i == SEL_KEY);
  assign ev_nonce = ev && (pad_sel_i == SEL_NONCE);
  assign ev_dat   = ev && (pad_sel_i == SEL_DATA);
  assign ev_cmd   = ev && (pad_sel_i == SEL_CMD);

  assign kn_vld_o   = key_full & nonce_full;
  assign blk_vld_o  = (state == S_FULL);
  assign pad_busy_o = (state == S_FULL);

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      key_o      <= '0;
      nonce_o    <= '0;
      key_cnt    <= '0;
      nonce_cnt  <= '0;
      key_full   <= 1'b0;
      nonce_full <= 1'b0;
      blk_dat_o  <= '0;
      blk_last_o <= 1'b0;
      last_pend  <= 1'b0;
      state      <= S_IDLE;
      start_o    <= 1'b0;
      mode_o     <= 1'b0;
      err_o      <= 1'b0;
    end else begin
      start_o <= 1'b0;

      if (ev_key) begin
        key_o   <= {key_o[95:0], pad_dat_i};
        key_cnt <= key_cnt + 2'd1;
        if (key_cnt == 2'd3) key_full <= 1'b1;
      end
      if (ev_nonce) begin
        nonce_o   <= {nonce_o[95:0], pad_dat_i};
        nonce_cnt <= nonce_cnt + 2'd1;
        if (nonce_cnt == 2'd3) nonce_full <= 1'b1;
      end

      case (state)
        S_IDLE: if (ev_dat) begin
          blk_dat_o[63:32] <= pad_dat_i;
          state            <= S_HALF;
        end
        S_HALF: if (ev_dat) begin
          blk_dat_o[31:0] <= pad_dat_i;
          blk_last_o      <= last_pend;
          state           <= S_FULL;
        end
        S_FULL: begin
          if (blk_rdy_i) begin
            // a pending-last request only retires with the block that carried it
            if (blk_last_o) last_pend <= 1'b0;
            blk_last_o <= 1'b0;
            state      <= S_IDLE;
            if (ev_dat) begin
              blk_dat_o[63:32] <= pad_dat_i;
              state            <= S_HALF;
            end
          end else if (ev_dat) begin
            err_o <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase

      if (ev_cmd) begin
        mode_o <= pad_dat_i[CMD_MODE];
        if (pad_dat_i[CMD_CLEAR]) begin
          err_o      <= 1'b0;
          key_cnt    <= '0;
          nonce_cnt  <= '0;
          key_full   <= 1'b0;
          nonce_full <= 1'b0;
          last_pend  <= 1'b0;
          blk_last_o <= 1'b0;
          state      <= S_IDLE;
        end else begin
          if (pad_dat_i[CMD_START]) begin
            if (kn_vld_o) start_o <= 1'b1;
            else          err_o   <= 1'b1;
          end
          if (pad_dat_i[CMD_LAST]) last_pend <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_ascon_io_loader.sv
// Bench for ascon_io_loader: word-level reference model checked every cycle, plus directed literals.
module tb_ascon_io_loader;

`ifdef ASCON_LOADER_STB_SYNC_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 1;
`endif

  logic         clk = 1'b0;
  logic         rst_n;
  logic [31:0]  pad_dat = '0;
  logic [1:0]   pad_sel = '0;
  logic         pad_stb = 1'b0;
  logic         blk_rdy = 1'b0;
  logic         pad_busy, kn_vld, blk_vld, blk_last, start, mode, err;
  logic [127:0] key, nonce;
  logic [63:0]  blk_dat;

  always #5 clk = ~clk;

  ascon_io_loader dut (
    .wb_clk_i(clk), .wb_rst_ni(rst_n),
    .pad_dat_i(pad_dat), .pad_sel_i(pad_sel), .pad_stb_i(pad_stb),
    .pad_busy_o(pad_busy), .key_o(key), .nonce_o(nonce), .kn_vld_o(kn_vld),
    .blk_dat_o(blk_dat), .blk_vld_o(blk_vld), .blk_last_o(blk_last), .blk_rdy_i(blk_rdy),
    .start_o(start), .mode_o(mode), .err_o(err)
  );

  int total = 0;
  int bad = 0;
  int start_cnt = 0;
  bit started = 0;
  bit done = 0;

  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model (word/block level) ----------------
  logic        m_ev = 0;
  logic [1:0]  m_sel = '0;
  logic [31:0] m_w = '0;
  logic [31:0] mk_q[$];
  logic [31:0] mn_q[$];
  int          mk_cnt = 0, mn_cnt = 0;   // words since last clear/reset
  int          m_nw = 0;                 // words held in the current block
  logic [63:0] m_dat = '0;
  logic        m_last = 0, m_pend = 0, m_start = 0, m_mode = 0, m_err = 0;

  function automatic logic [127:0] last4(input logic [31:0] q[$]);
    logic [127:0] r = '0;
    int lo = (q.size() > 4) ? q.size() - 4 : 0;
    for (int i = lo; i < q.size(); i++) r = {r[95:0], q[i]};
    return r;
  endfunction

  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        mk_q.delete(); mn_q.delete();
        mk_cnt = 0; mn_cnt = 0; m_nw = 0; m_dat = '0;
        m_last = 0; m_pend = 0; m_start = 0; m_mode = 0; m_err = 0;
      end else begin
        m_start = 0;
        if (m_nw == 2 && blk_rdy) begin
          m_nw = 0;
          if (m_last) m_pend = 0;
          m_last = 0;
        end
        if (m_ev) begin
          case (m_sel)
            2'd0: begin mk_q.push_back(m_w); mk_cnt++; end
            2'd1: begin mn_q.push_back(m_w); mn_cnt++; end
            2'd2: begin
              if (m_nw == 2) m_err = 1;
              else if (m_nw == 0) begin m_dat[63:32] = m_w; m_nw = 1; end
              else begin m_dat[31:0] = m_w; m_nw = 2; m_last = m_pend; end
            end
            default: begin
              m_mode = m_w[1];
              if (m_w[3]) begin
                m_err = 0; mk_cnt = 0; mn_cnt = 0; m_pend = 0; m_nw = 0; m_last = 0;
              end else begin
                if (m_w[0]) begin
                  if (mk_cnt >= 4 && mn_cnt >= 4) m_start = 1;
                  else m_err = 1;
                end
                if (m_w[2]) m_pend = 1;
              end
            end
          endcase
        end
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  initial begin
    wait (started);
    while (!done) begin
      @(negedge clk);
      if (start) start_cnt++;
      check("key", key, last4(mk_q));
      check("nonce", nonce, last4(mn_q));
      check("kn_vld", 128'(kn_vld), 128'(mk_cnt >= 4 && mn_cnt >= 4));
      check("blk_vld", 128'(blk_vld), 128'(m_nw == 2));
      check("busy", 128'(pad_busy), 128'(m_nw == 2));
      check("blk_last", 128'(blk_last), 128'(m_last));
      check("start", 128'(start), 128'(m_start));
      check("mode", 128'(mode), 128'(m_mode));
      check("err", 128'(err), 128'(m_err));
      if (m_nw == 2) check("blk_dat", 128'(blk_dat), 128'(m_dat));
    end
  end

  // One word transfer; optionally raises blk_rdy in the event cycle.
  task automatic send(input logic [1:0] s, input logic [31:0] w, input logic rdy = 1'b0);
    @(negedge clk);
    pad_sel = s; pad_dat = w; pad_stb = 1'b1;
    repeat (LAT - 1) @(negedge clk);
    m_ev = 1'b1; m_sel = s; m_w = w; blk_rdy = rdy;
    @(negedge clk);
    m_ev = 1'b0; blk_rdy = 1'b0; pad_stb = 1'b0;
    repeat (LAT) @(negedge clk);
  endtask

  task automatic rdy_pulse();
    @(negedge clk); blk_rdy = 1'b1;
    @(negedge clk); blk_rdy = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int sc;
    int lat;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_key", key, '0);
    check("rst_nonce", nonce, '0);
    check("rst_outs", 128'({kn_vld, blk_vld, blk_last, start, mode, err, pad_busy}), '0);
    rst_n = 1'b1;
    started = 1;
    repeat (3) @(negedge clk);

    send(2'd3, 32'h1);
    check("err_nokn", 128'(err), 128'(1));
    check("no_start", 128'(start_cnt), 128'(0));
    send(2'd3, 32'h8);
    check("err_clr", 128'(err), 128'(0));

    for (int i = 0; i < 4; i++) send(2'd0, 32'h00010203 + 32'h04040404 * i);
    for (int i = 0; i < 4; i++) send(2'd1, 32'h00010203 + 32'h04040404 * i);
    check("key_lit", key, 128'h000102030405060708090A0B0C0D0E0F);
    check("nonce_lit", nonce, 128'h000102030405060708090A0B0C0D0E0F);
    check("kn_lit", 128'(kn_vld), 128'(1));

    sc = start_cnt;
    send(2'd3, 32'h3);
    check("start_once", 128'(start_cnt - sc), 128'(1));
    check("mode_lit", 128'(mode), 128'(1));

    send(2'd2, 32'hDEADBEEF);
    send(2'd2, 32'h01234567);
    check("blk_vld_lit", 128'(blk_vld), 128'(1));
    check("blk_dat_lit", 128'(blk_dat), 128'(64'hDEADBEEF01234567));
    check("busy_lit", 128'(pad_busy), 128'(1));
    send(2'd2, 32'hCAFEF00D);
    check("overrun_err", 128'(err), 128'(1));
    check("overrun_keep", 128'(blk_dat), 128'(64'hDEADBEEF01234567));
    rdy_pulse();
    @(negedge clk);
    check("hs_vld", 128'(blk_vld), 128'(0));

    send(2'd3, 32'h8);
    check("clr_err", 128'(err), 128'(0));
    check("clr_kn", 128'(kn_vld), 128'(0));
    check("clr_key_kept", key, 128'h000102030405060708090A0B0C0D0E0F);

    send(2'd3, 32'h4);
    send(2'd2, 32'hAAAA0001);
    send(2'd2, 32'hBBBB0002);
    check("last_lit", 128'(blk_last), 128'(1));
    send(2'd2, 32'hCCCC0003, 1'b1);
    check("hs_load_half", 128'(blk_vld), 128'(0));
    check("hs_load_noerr", 128'(err), 128'(0));
    send(2'd2, 32'hDDDD0004);
    check("next_not_last", 128'(blk_last), 128'(0));
    check("hs_load_dat", 128'(blk_dat), 128'(64'hCCCC0003DDDD0004));
    rdy_pulse();

    send(2'd0, 32'h11111111);
    check("key_5th", key, 128'h0405060708090A0B0C0D0E0F11111111);

    fork
      send(2'd0, 32'h5A5A5A5A);
      begin
        wait (pad_stb);
        lat = 0;
        while (key[31:0] != 32'h5A5A5A5A && lat < 10) begin
          @(posedge clk); #1;
          lat++;
        end
      end
    join
    check("stb_latency", 128'(lat), 128'(LAT));

    send(2'd2, 32'hE0E0E0E0);
    send(2'd2, 32'hF1F1F1F1);
    check("pre_rst_vld", 128'(blk_vld), 128'(1));
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    check("arst_key", key, '0);
    check("arst_dat", 128'(blk_dat), '0);
    check("arst_outs", 128'({kn_vld, blk_vld, blk_last, start, mode, err, pad_busy}), '0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    check("rel_no_event", 128'({blk_vld, pad_busy, err}), '0);
    check("rel_key", key, '0);
    send(2'd0, 32'h12345678);
    check("post_rst_key", key, 128'h00000000000000000000000012345678);

    done = 1;
    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
